// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the 8N1 UART receiver
// Contents: rx_state_t (receiver FSM states), DATA_BITS, calc_clks_per_bit().
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    CLEANUP
  } rx_state_t;

  // Clocks per serial bit; integer division truncates (2812 at 27 MHz / 9600).
  function automatic int calc_clks_per_bit(input int clk_freq_hz, input int baud_rate);
    return clk_freq_hz / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for an asynchronous input
// Ports:
//   clk   - destination clock
//   reset - asynchronous active-low reset; both flops load RESET_VAL
//   d     - asynchronous input
//   q     - synchronized output (2-cycle latency)
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, oversampled by the system clock
// Ports:
//   clk         - system clock, rising edge
//   reset       - asynchronous active-low reset
//   rx          - serial line, idle high, asynchronous to clk
//   data_out    - last correctly framed byte, held until the next good frame
//   data_valid  - one-cycle pulse when data_out is updated
//   frame_error - one-cycle pulse when the stop bit samples low
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 27000000,
  parameter int BAUD_RATE    = 9600,
  parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUD_RATE),
  parameter int MSB_FIRST    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_error
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

  rx_state_t              state, state_nxt;
  logic                   rx_s;
  logic [CNT_W-1:0]       clk_cnt;
  logic [2:0]             bit_idx;
  logic [DATA_BITS-1:0]   shift_reg;
  // Cleared by a framing error; a start edge is accepted only once the
  // line has been seen high again, so a held break yields a single error.
  logic                   armed;

  logic half_done, bit_done;
  logic sample_bit, load_data, set_err;

  assign half_done = (clk_cnt == HALF_LAST);
  assign bit_done  = (clk_cnt == BIT_LAST);

  uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (armed && !rx_s) state_nxt = START;
      START:   if (half_done) state_nxt = rx_s ? IDLE : DATA;
      DATA:    if (bit_done && bit_idx == IDX_LAST) state_nxt = STOP;
      STOP:    if (bit_done) state_nxt = CLEANUP;
      CLEANUP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath control decode
  always_comb begin
    sample_bit = 1'b0;
    load_data  = 1'b0;
    set_err    = 1'b0;
    case (state)
      DATA: sample_bit = bit_done;
      STOP: begin
        load_data = bit_done && rx_s;
        set_err   = bit_done && !rx_s;
      end
      default: ;
    endcase
  end

  // Datapath: counters, shift register, held output, pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      armed       <= 1'b1;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      data_valid  <= load_data;
      frame_error <= set_err;

      case (state)
        START:      clk_cnt <= half_done ? '0 : clk_cnt + 1'b1;
        DATA, STOP: clk_cnt <= bit_done  ? '0 : clk_cnt + 1'b1;
        default:    clk_cnt <= '0;
      endcase

      if (state == IDLE)   bit_idx <= '0;
      else if (sample_bit) bit_idx <= bit_idx + 3'd1;

      if (sample_bit) begin
        if (MSB_FIRST != 0) shift_reg <= {shift_reg[DATA_BITS-2:0], rx_s};
        else                shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
      end

      if (load_data) data_out <= shift_reg;

      if (set_err)                          armed <= 1'b0;
      else if (state == IDLE && rx_s)       armed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx (MSB-first and LSB-first instances)
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CLK_HZ = 27000000;
  localparam int BAUD   = 843750;
  localparam int CPB    = CLK_HZ / BAUD;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] dout_m, dout_l;
  logic       dv_m, dv_l, fe_m, fe_l;

  always #18.518 clk = ~clk;

  uart_rx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .MSB_FIRST(1)) dut_m (
    .clk(clk), .reset(reset), .rx(rx),
    .data_out(dout_m), .data_valid(dv_m), .frame_error(fe_m)
  );

  uart_rx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .MSB_FIRST(0)) dut_l (
    .clk(clk), .reset(reset), .rx(rx),
    .data_out(dout_l), .data_valid(dv_l), .frame_error(fe_l)
  );

  int checks = 0;
  int failures = 0;

  int nv_m = 0, nv_l = 0, ne_m = 0, ne_l = 0;
  logic [7:0] got_m[$];
  logic [7:0] got_l[$];

  always @(negedge clk) begin
    if (dv_m) begin nv_m++; got_m.push_back(dout_m); end
    if (dv_l) begin nv_l++; got_l.push_back(dout_l); end
    if (fe_m) ne_m++;
    if (fe_l) ne_l++;
  end

  // Reference model: the held byte each instance should present.
  logic [7:0] exp_m = 8'h00;
  logic [7:0] exp_l = 8'h00;

  int vm, vl, em, el;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic snap();
    vm = nv_m; vl = nv_l; em = ne_m; el = ne_l;
  endtask

  // seq[7] goes on the line first, seq[0] last.
  task automatic send_frame(input logic [7:0] seq, input logic stop);
    rx = 1'b0; tick(CPB);
    for (int i = 0; i < 8; i++) begin rx = seq[7-i]; tick(CPB); end
    rx = stop; tick(CPB);
    rx = 1'b1;
    if (stop) begin exp_m = seq; exp_l = rev8(seq); end
  endtask

  task automatic test_reset();
    reset = 1'b0; rx = 1'b1;
    #74000;
    checks++;
    if ({dout_m, dv_m, fe_m, dout_l, dv_l, fe_l} !== 20'h0) begin
      failures++;
      $display("FAIL reset_hold: got m=%h/%b/%b l=%h/%b/%b want all zero", dout_m, dv_m, fe_m, dout_l, dv_l, fe_l);
    end
    tick(1); reset = 1'b1;
    snap();
    tick(4 * CPB);
    checks++;
    if (dout_m !== exp_m || dout_l !== exp_l) begin
      failures++;
      $display("FAIL reset_idle_data: got m=%h l=%h want m=%h l=%h", dout_m, dout_l, exp_m, exp_l);
    end
    checks++;
    if (nv_m != vm || nv_l != vl || ne_m != em || ne_l != el) begin
      failures++;
      $display("FAIL reset_idle_pulses: got valid=%0d/%0d err=%0d/%0d want 0", nv_m - vm, nv_l - vl, ne_m - em, ne_l - el);
    end
  endtask

  task automatic test_pattern();
    snap();
    send_frame(8'hAA, 1'b1);
    tick(CPB);
    checks++;
    if (nv_m - vm != 1 || nv_l - vl != 1) begin
      failures++;
      $display("FAIL pattern_valid_count: got %0d/%0d want 1/1", nv_m - vm, nv_l - vl);
    end
    checks++;
    if (dout_m !== 8'hAA) begin
      failures++;
      $display("FAIL pattern_msb_first: got %h want aa", dout_m);
    end
    checks++;
    if (dout_l !== 8'h55) begin
      failures++;
      $display("FAIL pattern_lsb_first: got %h want 55", dout_l);
    end
  endtask

  task automatic test_glitch();
    snap();
    rx = 1'b0; tick(CPB / 3);
    rx = 1'b1; tick(3 * CPB);
    checks++;
    if (nv_m != vm || nv_l != vl || ne_m != em || ne_l != el) begin
      failures++;
      $display("FAIL glitch_pulses: got valid=%0d/%0d err=%0d/%0d want 0", nv_m - vm, nv_l - vl, ne_m - em, ne_l - el);
    end
    checks++;
    if (dout_m !== exp_m || dout_l !== exp_l) begin
      failures++;
      $display("FAIL glitch_data: got m=%h l=%h want m=%h l=%h", dout_m, dout_l, exp_m, exp_l);
    end
  endtask

  task automatic test_stop_error();
    snap();
    send_frame(8'h3C, 1'b0);
    tick(CPB);
    checks++;
    if (ne_m - em != 1 || ne_l - el != 1 || nv_m != vm || nv_l != vl) begin
      failures++;
      $display("FAIL stop_error_pulses: got err=%0d/%0d valid=%0d/%0d want 1/1 0/0", ne_m - em, ne_l - el, nv_m - vm, nv_l - vl);
    end
    checks++;
    if (dout_m !== 8'hAA || dout_l !== exp_l) begin
      failures++;
      $display("FAIL stop_error_hold: got m=%h l=%h want m=aa l=%h", dout_m, dout_l, exp_l);
    end
  endtask

  task automatic test_back_to_back();
    int qm, ql;
    snap();
    qm = got_m.size(); ql = got_l.size();
    send_frame(8'h12, 1'b1);
    send_frame(8'hFE, 1'b1);
    tick(CPB);
    checks++;
    if (nv_m - vm != 2 || nv_l - vl != 2 || got_m.size() < qm + 2 || got_l.size() < ql + 2) begin
      failures++;
      $display("FAIL b2b_valid_count: got %0d/%0d want 2/2", nv_m - vm, nv_l - vl);
    end else begin
      checks++;
      if (got_m[qm] !== 8'h12 || got_m[qm+1] !== 8'hFE) begin
        failures++;
        $display("FAIL b2b_msb_seq: got %h,%h want 12,fe", got_m[qm], got_m[qm+1]);
      end
      checks++;
      if (got_l[ql] !== rev8(8'h12) || got_l[ql+1] !== rev8(8'hFE)) begin
        failures++;
        $display("FAIL b2b_lsb_seq: got %h,%h want %h,%h", got_l[ql], got_l[ql+1], rev8(8'h12), rev8(8'hFE));
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] seq;
    logic       stop;
    for (int n = 0; n < 10; n++) begin
      seq  = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      snap();
      send_frame(seq, stop);
      tick(CPB + $urandom_range(0, CPB));
      checks++;
      if (nv_m - vm != int'(stop) || nv_l - vl != int'(stop) ||
          ne_m - em != int'(!stop) || ne_l - el != int'(!stop)) begin
        failures++;
        $display("FAIL random_pulses[%0d]: got valid=%0d/%0d err=%0d/%0d stop=%b", n, nv_m - vm, nv_l - vl, ne_m - em, ne_l - el, stop);
      end
      checks++;
      if (dout_m !== exp_m || dout_l !== exp_l) begin
        failures++;
        $display("FAIL random_data[%0d]: got m=%h l=%h want m=%h l=%h", n, dout_m, dout_l, exp_m, exp_l);
      end
    end
  endtask

  task automatic test_break();
    logic [7:0] seq;
    snap();
    rx = 1'b0; tick(12 * CPB);
    checks++;
    if (ne_m - em != 1 || ne_l - el != 1 || nv_m != vm || nv_l != vl) begin
      failures++;
      $display("FAIL break_error: got err=%0d/%0d valid=%0d/%0d want 1/1 0/0", ne_m - em, ne_l - el, nv_m - vm, nv_l - vl);
    end
    tick(10 * CPB);
    checks++;
    if (ne_m - em != 1 || ne_l - el != 1) begin
      failures++;
      $display("FAIL break_rearm: got err=%0d/%0d want 1/1 while line held low", ne_m - em, ne_l - el);
    end
    rx = 1'b1; tick(2 * CPB);
    seq = 8'($urandom);
    snap();
    send_frame(seq, 1'b1);
    tick(CPB);
    checks++;
    if (nv_m - vm != 1 || dout_m !== exp_m || dout_l !== exp_l) begin
      failures++;
      $display("FAIL break_recover: got valid=%0d m=%h l=%h want 1 m=%h l=%h", nv_m - vm, dout_m, dout_l, exp_m, exp_l);
    end
  endtask

  task automatic test_reset_mid_frame();
    snap();
    rx = 1'b0; tick(CPB);
    for (int i = 0; i < 4; i++) begin rx = i[0]; tick(CPB); end
    rx = 1'b1; tick(CPB / 2);
    reset = 1'b0;
    #1;
    exp_m = 8'h00; exp_l = 8'h00;
    checks++;
    if ({dout_m, dv_m, fe_m, dout_l, dv_l, fe_l} !== 20'h0) begin
      failures++;
      $display("FAIL reset_mid_async: got m=%h/%b/%b l=%h/%b/%b want all zero", dout_m, dv_m, fe_m, dout_l, dv_l, fe_l);
    end
    tick(3);
    reset = 1'b1;
    tick(2 * CPB);
    checks++;
    if (nv_m != vm || nv_l != vl || ne_m != em || ne_l != el) begin
      failures++;
      $display("FAIL reset_mid_pulses: got valid=%0d/%0d err=%0d/%0d want 0", nv_m - vm, nv_l - vl, ne_m - em, ne_l - el);
    end
    snap();
    send_frame(8'hC3, 1'b1);
    tick(CPB);
    checks++;
    if (nv_m - vm != 1 || nv_l - vl != 1 || dout_m !== 8'hC3 || dout_l !== rev8(8'hC3)) begin
      failures++;
      $display("FAIL reset_mid_next: got valid=%0d/%0d m=%h l=%h want 1/1 c3 %h", nv_m - vm, nv_l - vl, dout_m, dout_l, rev8(8'hC3));
    end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_glitch();
    test_stop_error();
    test_back_to_back();
    test_random();
    test_break();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
